// File: rtl/dlatch_ctrl_pkg.sv
// Shared types and constant helpers for the dlatch write-side controller.
//   state_e : controller FSM states
//   clog2   : counter width helper (never returns less than 1)
//   max3    : largest of three ints, used to size the shared counter
package dlatch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OPEN = 3'd1,
    HOLD = 3'd2,
    REQ  = 3'd3,
    RTZ  = 3'd4
  } state_e;

  // Ceiling log2, floored at 1 so a zero-width vector can never be declared.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x * 2;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dlatch_tx_ctrl_if.sv
// Input word handshake (valid/ready + data) into the dlatch controller.
//   in_valid : producer has a word
//   in_ready : controller can take it
//   in_data  : the word, N bits
// master = producer side, slave = controller side.
interface dlatch_tx_ctrl_if #(
  parameter int N = 1
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/dlatch_tx_ctrl_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit.
//   clk, rst : clock and synchronous active-high reset (chain clears to 0)
//   d        : asynchronous input
//   q        : synchronised output, STAGES edges of latency
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Bit 0 is the metastability-catching flop; the MSB is the only tap used.
  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dlatch_tx_ctrl.sv
// Write-side controller for a bank of N transparent d-latches.
// Takes a valid/ready word, opens the latch bank for OPEN_CYC cycles, holds
// lat_d for HOLD_CYC more, then runs a 4-phase RTZ req/ack handshake with an
// asynchronous consumer. ack_i is only ever seen through the synchroniser.
//   clk, rst      : clock, synchronous active-high reset
//   in_if (slave) : in_valid / in_ready / in_data word handshake
//   lat_d, lat_en : registered data / enable to the latch bank
//   lat_rst       : latch-bank reset, Rpol during rst else ~Rpol (combinational)
//   req_o, ack_i  : 4-phase request (registered) / async acknowledge
//   busy          : FSM not in IDLE
//   err           : sticky handshake timeout flag (TIMEOUT=0 disables)
module dlatch_tx_ctrl
  import dlatch_ctrl_pkg::*;
#(
  parameter int   N           = 1,
  parameter int   OPEN_CYC    = 2,
  parameter int   HOLD_CYC    = 1,
  parameter int   SYNC_STAGES = 2,
  parameter int   TIMEOUT     = 0,
  parameter logic Rpol        = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  dlatch_tx_ctrl_if.slave in_if,
  output logic [N-1:0]   lat_d,
  output logic           lat_en,
  output logic           lat_rst,
  output logic           req_o,
  input  logic           ack_i,
  output logic           busy,
  output logic           err
);

  // One counter serves the OPEN/HOLD windows and the REQ/RTZ wait timer;
  // the phases never overlap, so it only needs to cover the largest limit.
  localparam int CNT_W = clog2(max3(OPEN_CYC, HOLD_CYC, TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     lat_d_q, lat_d_d;
  logic             lat_en_q, lat_en_d;
  logic             req_q, req_d;
  logic             err_q, err_d;

  logic             ack_s;
  logic             in_ready;
  logic             accept;
  logic             open_last;
  logic             hold_last;
  logic             wait_st;
  logic             leave_wait;
  logic             wait_sat;
  logic             to_hit;
  logic [CNT_W-1:0] cnt_inc;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_i),
    .q   (ack_s)
  );

  // Never offer a word while the consumer still shows ack high: a stuck ack
  // would otherwise be read as an instant acknowledge of the next request.
  assign in_ready  = (state_q == IDLE) && !ack_s && !rst;
  assign accept    = in_if.in_valid && in_ready;
  assign open_last = (state_q == OPEN) && (cnt_q == OPEN_LAST);
  assign hold_last = (state_q == HOLD) && (cnt_q == HOLD_LAST);
  assign cnt_inc   = cnt_q + 1'b1;

  // Wait timer: saturates at TIMEOUT; err fires on the edge the count
  // would reach the limit while the handshake is still pending.
  assign wait_st    = (state_q == REQ) || (state_q == RTZ);
  assign leave_wait = ((state_q == REQ) && ack_s) || ((state_q == RTZ) && !ack_s);
  assign wait_sat   = (cnt_q == TO_LIM);
  assign to_hit     = (TIMEOUT > 0) && wait_st && !leave_wait && (cnt_inc == TO_LIM);

  // State register (all flops)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lat_d_q  <= '0;
      lat_en_q <= 1'b0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
      req_q    <= req_d;
      err_q    <= err_d;
    end
  end

  // Next-state and counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = OPEN;
          cnt_d   = '0;
        end
      end
      OPEN: begin
        if (open_last) begin
          state_d = (HOLD_CYC > 0) ? HOLD : REQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HOLD: begin
        if (hold_last) begin
          state_d = REQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REQ: begin
        if (ack_s) begin
          state_d = RTZ;
          cnt_d   = '0;
        end else if (!wait_sat) begin
          cnt_d = cnt_inc;
        end
      end
      RTZ: begin
        if (!ack_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!wait_sat) begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: next values of the registered outputs plus the
  // combinational ones.
  always_comb begin
    lat_d_d  = lat_d_q;
    lat_en_d = lat_en_q;
    req_d    = req_q;
    err_d    = err_q | to_hit;

    // lat_d moves only on an accept, so it is stable from lat_en rise
    // until the next word is taken in IDLE.
    if (accept) begin
      lat_d_d  = in_if.in_data;
      lat_en_d = 1'b1;
    end
    if (open_last) lat_en_d = 1'b0;

    // req_o is a flop output, so it cannot glitch toward the consumer.
    if ((open_last && (HOLD_CYC == 0)) || hold_last) req_d = 1'b1;
    if ((state_q == REQ) && ack_s)                  req_d = 1'b0;
  end

  assign in_if.in_ready = in_ready;
  assign lat_d          = lat_d_q;
  assign lat_en         = lat_en_q;
  assign req_o          = req_q;
  assign err            = err_q;
  assign busy           = (state_q != IDLE);
  assign lat_rst        = rst ? Rpol : ~Rpol;

endmodule

// File: tb/tb_dlatch_tx_ctrl.sv
// Testbench for dlatch_tx_ctrl: cycle vector table for reset, a single word
// and back-to-back words, followed by directed sequences for stuck ack,
// timeout and reset in the middle of a request.
module tb_dlatch_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ack_i;
  logic [7:0] lat_d;
  logic       lat_en, lat_rst, req_o, busy, err;

  int n_cmp = 0;
  int n_err = 0;

  dlatch_tx_ctrl_if #(.N(8)) in_if ();

  dlatch_tx_ctrl #(
    .N(8), .OPEN_CYC(2), .HOLD_CYC(1), .SYNC_STAGES(2), .TIMEOUT(16), .Rpol(1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_if   (in_if),
    .lat_d   (lat_d),
    .lat_en  (lat_en),
    .lat_rst (lat_rst),
    .req_o   (req_o),
    .ack_i   (ack_i),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst, vld;
    bit [7:0] data;
    bit       ack;
    bit       rdy, en;
    bit [7:0] d;
    bit       req, bsy, er, lrst;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r, input bit v, input bit [7:0] dat, input bit a,
                     input bit e_rdy, input bit e_en, input bit [7:0] e_d,
                     input bit e_req, input bit e_bsy, input bit e_er, input bit e_lrst);
    vec_t x;
    x.rst = r; x.vld = v; x.data = dat; x.ack = a;
    x.rdy = e_rdy; x.en = e_en; x.d = e_d; x.req = e_req;
    x.bsy = e_bsy; x.er = e_er; x.lrst = e_lrst;
    vq.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one edge, settle 1 time unit past it.
  task automatic step(input bit r, input bit v, input bit [7:0] dat, input bit a);
    rst = r;
    in_if.in_valid = v;
    in_if.in_data  = dat;
    ack_i = a;
    @(posedge clk);
    #1;
  endtask

  // Wait for req (ack low), then ack high until req drops, then ack low
  // until the controller is idle again. Every wait is bounded.
  task automatic complete_hs(input string tag);
    int k;
    k = 0;
    while (req_o !== 1'b1 && k < 10) begin step(0, 0, 8'h00, 0); k++; end
    chk({tag, "_req_rise"}, req_o, 1);
    k = 0;
    while (req_o !== 1'b0 && k < 10) begin step(0, 0, 8'h00, 1); k++; end
    chk({tag, "_req_fall"}, req_o, 0);
    k = 0;
    while (busy !== 1'b0 && k < 10) begin step(0, 0, 8'h00, 0); k++; end
    chk({tag, "_idle"}, busy, 0);
  endtask

  // Accept at E0 and walk the full handshake with hand-timed ack edges.
  task automatic single_word(input bit [7:0] w, input string tag);
    step(0, 1, w, 0);     chk({tag, "_e0_en"}, lat_en, 1); chk({tag, "_e0_d"}, lat_d, w);
                          chk({tag, "_e0_rdy"}, in_if.in_ready, 0);
    step(0, 0, 8'hFF, 0); chk({tag, "_e1_en"}, lat_en, 1); chk({tag, "_e1_d"}, lat_d, w);
    step(0, 0, 8'hFF, 0); chk({tag, "_e2_en"}, lat_en, 0); chk({tag, "_e2_req"}, req_o, 0);
    step(0, 0, 8'h00, 0); chk({tag, "_e3_req"}, req_o, 1);
    step(0, 0, 8'h00, 0); chk({tag, "_e4_req"}, req_o, 1);
    step(0, 0, 8'h00, 1); chk({tag, "_e5_req"}, req_o, 1);
    step(0, 0, 8'h00, 1); chk({tag, "_e6_req"}, req_o, 1);
    step(0, 0, 8'h00, 1); chk({tag, "_e7_req"}, req_o, 0); chk({tag, "_e7_busy"}, busy, 1);
    step(0, 0, 8'h00, 1); chk({tag, "_e8_req"}, req_o, 0);
    step(0, 0, 8'h00, 0); chk({tag, "_e9_rdy"}, in_if.in_ready, 0);
    step(0, 0, 8'h00, 0); chk({tag, "_e10_rdy"}, in_if.in_ready, 0);
    step(0, 0, 8'h00, 0); chk({tag, "_e11_rdy"}, in_if.in_ready, 1);
                          chk({tag, "_e11_busy"}, busy, 0); chk({tag, "_e11_d"}, lat_d, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ack_i = 1'b0; in_if.in_valid = 1'b0; in_if.in_data = 8'h00;

    //  rst vld data  ack | rdy en d     req bsy er lrst
    // reset for 3 edges, then release
    add(1, 0, 8'h00, 0,   0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0,   0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0,   0, 0, 8'h00, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0,   1, 0, 8'h00, 0, 0, 0, 1);
    // single word 0xA5, E0..E11
    add(0, 1, 8'hA5, 0,   0, 1, 8'hA5, 0, 1, 0, 1);
    add(0, 0, 8'hFF, 0,   0, 1, 8'hA5, 0, 1, 0, 1);
    add(0, 0, 8'hFF, 0,   0, 0, 8'hA5, 0, 1, 0, 1);
    add(0, 0, 8'h00, 0,   0, 0, 8'hA5, 1, 1, 0, 1);
    add(0, 0, 8'h00, 0,   0, 0, 8'hA5, 1, 1, 0, 1);
    add(0, 0, 8'h00, 1,   0, 0, 8'hA5, 1, 1, 0, 1);
    add(0, 0, 8'h00, 1,   0, 0, 8'hA5, 1, 1, 0, 1);
    add(0, 0, 8'h00, 1,   0, 0, 8'hA5, 0, 1, 0, 1);
    add(0, 0, 8'h00, 1,   0, 0, 8'hA5, 0, 1, 0, 1);
    add(0, 0, 8'h00, 0,   0, 0, 8'hA5, 0, 1, 0, 1);
    add(0, 0, 8'h00, 0,   0, 0, 8'hA5, 0, 1, 0, 1);
    add(0, 0, 8'h00, 0,   1, 0, 8'hA5, 0, 0, 0, 1);
    // back-to-back: valid held high, 0x11 then 0x22
    add(0, 1, 8'h11, 0,   0, 1, 8'h11, 0, 1, 0, 1);
    add(0, 1, 8'h22, 0,   0, 1, 8'h11, 0, 1, 0, 1);
    add(0, 1, 8'h22, 0,   0, 0, 8'h11, 0, 1, 0, 1);
    add(0, 1, 8'h22, 0,   0, 0, 8'h11, 1, 1, 0, 1);
    add(0, 1, 8'h22, 1,   0, 0, 8'h11, 1, 1, 0, 1);
    add(0, 1, 8'h22, 1,   0, 0, 8'h11, 1, 1, 0, 1);
    add(0, 1, 8'h22, 1,   0, 0, 8'h11, 0, 1, 0, 1);
    add(0, 1, 8'h22, 0,   0, 0, 8'h11, 0, 1, 0, 1);
    add(0, 1, 8'h22, 0,   0, 0, 8'h11, 0, 1, 0, 1);
    add(0, 1, 8'h22, 0,   1, 0, 8'h11, 0, 0, 0, 1);
    add(0, 1, 8'h22, 0,   0, 1, 8'h22, 0, 1, 0, 1);
    add(0, 0, 8'h00, 0,   0, 1, 8'h22, 0, 1, 0, 1);
    add(0, 0, 8'h00, 0,   0, 0, 8'h22, 0, 1, 0, 1);
    add(0, 0, 8'h00, 0,   0, 0, 8'h22, 1, 1, 0, 1);
    add(0, 0, 8'h00, 1,   0, 0, 8'h22, 1, 1, 0, 1);
    add(0, 0, 8'h00, 1,   0, 0, 8'h22, 1, 1, 0, 1);
    add(0, 0, 8'h00, 1,   0, 0, 8'h22, 0, 1, 0, 1);
    add(0, 0, 8'h00, 0,   0, 0, 8'h22, 0, 1, 0, 1);
    add(0, 0, 8'h00, 0,   0, 0, 8'h22, 0, 1, 0, 1);
    add(0, 0, 8'h00, 0,   1, 0, 8'h22, 0, 0, 0, 1);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].vld, vq[i].data, vq[i].ack);
      chk($sformatf("v%0d_rdy", i),  in_if.in_ready, vq[i].rdy);
      chk($sformatf("v%0d_en", i),   lat_en,  vq[i].en);
      chk($sformatf("v%0d_d", i),    lat_d,   vq[i].d);
      chk($sformatf("v%0d_req", i),  req_o,   vq[i].req);
      chk($sformatf("v%0d_busy", i), busy,    vq[i].bsy);
      chk($sformatf("v%0d_err", i),  err,     vq[i].er);
      chk($sformatf("v%0d_lrst", i), lat_rst, vq[i].lrst);
    end

    // Stuck ack: raise ack in IDLE first, then offer a word.
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    chk("stuck_rdy", in_if.in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'h5A, 1);
      chk($sformatf("stuck%0d_rdy", i), in_if.in_ready, 0);
      chk($sformatf("stuck%0d_en", i), lat_en, 0);
    end
    step(0, 1, 8'h5A, 0);
    chk("drop1_en", lat_en, 0); chk("drop1_rdy", in_if.in_ready, 0);
    step(0, 1, 8'h5A, 0);
    chk("drop2_en", lat_en, 0); chk("drop2_rdy", in_if.in_ready, 1);
    step(0, 1, 8'h5A, 0);
    chk("drop3_en", lat_en, 1); chk("drop3_d", lat_d, 8'h5A);
    complete_hs("stuck_hs");

    // Timeout: ack held low while in REQ; err after the 16th REQ cycle.
    step(0, 1, 8'h77, 0); chk("to_e0_en", lat_en, 1);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0); chk("to_e3_req", req_o, 1);
    for (int i = 4; i <= 18; i++) begin
      step(0, 0, 8'h00, 0);
      chk($sformatf("to_e%0d_err", i), err, 0);
      chk($sformatf("to_e%0d_req", i), req_o, 1);
    end
    step(0, 0, 8'h00, 0);
    chk("to_e19_err", err, 1); chk("to_e19_req", req_o, 1);
    for (int i = 20; i < 23; i++) begin
      step(0, 0, 8'h00, 0);
      chk($sformatf("to_e%0d_err", i), err, 1);
      chk($sformatf("to_e%0d_req", i), req_o, 1);
    end
    complete_hs("to_hs");
    chk("to_err_sticky", err, 1);
    chk("to_d", lat_d, 8'h77);
    chk("to_rdy", in_if.in_ready, 1);

    // Reset in the middle of REQ, then a clean word afterwards.
    step(0, 1, 8'h99, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0); chk("mr_req_pre", req_o, 1);
    step(1, 0, 8'h00, 0);
    chk("mr_req", req_o, 0);   chk("mr_en", lat_en, 0);  chk("mr_d", lat_d, 8'h00);
    chk("mr_busy", busy, 0);   chk("mr_err", err, 0);    chk("mr_rdy", in_if.in_ready, 0);
    chk("mr_lrst", lat_rst, 0);
    step(0, 0, 8'h00, 0);
    chk("mr_rel_rdy", in_if.in_ready, 1); chk("mr_rel_lrst", lat_rst, 1);
    single_word(8'h3C, "mr_sw");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
